// File: rtl/ldl_round_mux_pkg.sv
// ldl_round_mux_pkg: shared types and helpers for the packet-locked
// round-robin stream multiplexer (ldl_round_mux) and its pick unit.
//   state_e   : arbiter state (IDLE searching, LOCK holding a grant)
//   DEF_WIDTH : default channel count, DEF_SELW its index width
//   next_ptr  : wrapping increment of a channel index (explicit compare,
//               so non-power-of-two channel counts wrap correctly)
package ldl_round_mux_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_SELW  = $clog2(DEF_WIDTH);

  // Index after idx in a ring of width channels.
  function automatic int unsigned next_ptr(input int unsigned idx,
                                           input int unsigned width);
    if (idx == (width - 32'd1)) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/ldl_rr_pick.sv
// ldl_rr_pick: combinational rotate-priority search.
//   req   : per-channel request bits
//   ptr   : channel with highest priority this cycle
//   idx   : first requesting channel at or above ptr, wrapping to 0
//   found : at least one request present
module ldl_rr_pick #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned SEL_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  localparam logic [SEL_W:0] WIDTH_L = (SEL_W + 1)'(WIDTH);

  logic [2*WIDTH-1:0] dbl_s;
  logic [WIDTH-1:0]   rot_s;
  logic [SEL_W:0]     off_s;
  logic [SEL_W:0]     sum_s;

  // Rotate requests so bit 0 is the ptr channel, take the lowest set
  // offset, then map the offset back to an absolute channel index.
  always_comb begin
    dbl_s = {req, req};
    rot_s = WIDTH'(dbl_s >> ptr);
    off_s = {(SEL_W + 1){1'b0}};
    for (int i = WIDTH - 1; i >= 0; i--) begin
      off_s = rot_s[i] ? (SEL_W + 1)'(i) : off_s;
    end
    sum_s = {1'b0, ptr} + off_s;
    idx   = (sum_s >= WIDTH_L) ? SEL_W'(sum_s - WIDTH_L) : SEL_W'(sum_s);
    found = |req;
  end

endmodule

// File: rtl/ldl_round_mux.sv
// ldl_round_mux: packet-locked N:1 round-robin stream multiplexer.
// A requesting channel is chosen in round-robin order and keeps the grant
// until its last beat; beats pass through one registered output stage.
//   clk, rst_n          : clock, asynchronous active-low reset
//   s_valid/s_ready     : per-channel beat handshake (WIDTH bits)
//   s_data, s_last      : channel i data at [i*DW +: DW], end-of-packet
//   m_valid/m_ready     : output beat handshake
//   m_data, m_last      : output beat payload and end-of-packet
//   m_sel               : channel index of the current output beat
//   busy                : a grant is locked
// Optional build macro LDL_ROUND_MUX_BURST_LIMIT_EN: a grant is also
// released after MAX_BURST transfers, letting long packets interleave.
module ldl_round_mux
  import ldl_round_mux_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BURST = 16,
  localparam int unsigned SEL_W    = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    s_valid,
  output logic [WIDTH-1:0]    s_ready,
  input  logic [WIDTH*DW-1:0] s_data,
  input  logic [WIDTH-1:0]    s_last,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DW-1:0]       m_data,
  output logic                m_last,
  output logic [SEL_W-1:0]    m_sel,
  output logic                busy
);

  state_e           state_r;
  logic [SEL_W-1:0] ptr_r;
  logic [SEL_W-1:0] gnt_r;

  logic             m_valid_r;
  logic [DW-1:0]    m_data_r;
  logic             m_last_r;
  logic [SEL_W-1:0] m_sel_r;

  logic [SEL_W-1:0] pick_idx_s;
  logic             pick_found_s;
  logic [WIDTH-1:0] s_ready_s;
  logic             sel_valid_s;
  logic             sel_last_s;
  logic [DW-1:0]    sel_data_s;
  logic             out_free_s;
  logic             xfer_s;
  logic             burst_hit_s;
  logic             release_s;

  ldl_rr_pick #(
    .WIDTH (WIDTH)
  ) u_pick (
    .req   (s_valid),
    .ptr   (ptr_r),
    .idx   (pick_idx_s),
    .found (pick_found_s)
  );

  // Output stage can take a beat when empty or draining this cycle.
  assign out_free_s = !m_valid_r || m_ready;

  // Route the granted channel to the output stage and open only its ready.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = {DW{1'b0}};
    s_ready_s   = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      s_ready_s[i] = (state_r == LOCK) && (gnt_r == SEL_W'(i)) && out_free_s;
      sel_valid_s  = (gnt_r == SEL_W'(i)) ? s_valid[i]          : sel_valid_s;
      sel_last_s   = (gnt_r == SEL_W'(i)) ? s_last[i]           : sel_last_s;
      sel_data_s   = (gnt_r == SEL_W'(i)) ? s_data[i*DW +: DW]  : sel_data_s;
    end
  end

  assign xfer_s    = (state_r == LOCK) && sel_valid_s && out_free_s;
  assign release_s = xfer_s && (sel_last_s || burst_hit_s);

`ifdef LDL_ROUND_MUX_BURST_LIMIT_EN
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  logic [CNT_W-1:0] cnt_r;

  // The transfer about to happen is the MAX_BURST-th of this grant.
  assign burst_hit_s = (cnt_r == CNT_W'(MAX_BURST - 1));

  // Beats transferred under the current grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == IDLE) && pick_found_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (xfer_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end
`else
  // MAX_BURST only matters when the burst limit is compiled in.
  logic max_burst_unused_s;
  assign max_burst_unused_s = (MAX_BURST == 32'd0);
  assign burst_hit_s        = 1'b0;
`endif

  // Arbitration state: search in IDLE, hold the grant in LOCK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= {SEL_W{1'b0}};
      gnt_r   <= {SEL_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_found_s) begin
            gnt_r   <= pick_idx_s;
            state_r <= LOCK;
          end
        end
        LOCK: begin
          if (release_s) begin
            state_r <= IDLE;
            ptr_r   <= SEL_W'(next_ptr(32'(gnt_r), WIDTH));
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Output register: load on transfer, clear on drain, hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_r <= 1'b0;
      m_data_r  <= {DW{1'b0}};
      m_last_r  <= 1'b0;
      m_sel_r   <= {SEL_W{1'b0}};
    end else if (xfer_s) begin
      m_valid_r <= 1'b1;
      m_data_r  <= sel_data_s;
      m_last_r  <= sel_last_s;
      m_sel_r   <= gnt_r;
    end else if (m_ready) begin
      m_valid_r <= 1'b0;
    end
  end

  assign s_ready = s_ready_s;
  assign m_valid = m_valid_r;
  assign m_data  = m_data_r;
  assign m_last  = m_last_r;
  assign m_sel   = m_sel_r;
  assign busy    = (state_r == LOCK);

endmodule

// File: tb/tb_ldl_round_mux.sv
// tb_ldl_round_mux: randomized and directed bench for ldl_round_mux.
// Per-channel packet queues drive the inputs; a packet-level round-robin
// model fills an expected-beat queue that a separate monitor pops on every
// output handshake. In stall-free phases each beat's cycle is also checked.
module tb_ldl_round_mux;

  localparam int W  = 8;
  localparam int DW = 32;
  localparam int MB = 4;
`ifdef LDL_ROUND_MUX_BURST_LIMIT_EN
  localparam int LIM     = MB;
  localparam int BUB_MAX = 0;
`else
  localparam int LIM     = 1 << 30;
  localparam int BUB_MAX = 20;
`endif

  logic            clk;
  logic            rst_n;
  logic [W-1:0]    s_valid;
  logic [W-1:0]    s_ready;
  logic [W*DW-1:0] s_data;
  logic [W-1:0]    s_last;
  logic            m_valid;
  logic            m_ready;
  logic [DW-1:0]   m_data;
  logic            m_last;
  logic [2:0]      m_sel;
  logic            busy;

  ldl_round_mux #(.WIDTH(W), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .m_sel(m_sel), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] d; logic l; } beat_t;
  typedef struct { logic [DW-1:0] d; logic l; int sel; int cyc; } exp_t;

  beat_t chq[W][$];
  int    st[W];
  bit    first_beat[W];
  exp_t  sbq[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc = 0;
  int    stall_pct, bubble_pct, stall_lo, stall_hi;

  task automatic clear_cfg();
    for (int i = 0; i < W; i++) begin
      chq[i].delete();
      st[i] = 0;
    end
    sbq.delete();
    stall_pct  = 0;
    bubble_pct = 0;
    stall_lo   = -1;
    stall_hi   = -1;
  endtask

  task automatic add_pkt(input int ch, input int len);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b.d = $urandom;
      b.l = (j == len - 1);
      chq[ch].push_back(b);
    end
  endtask

  // Packet-level round-robin: the lowest channel at or after ptr (mod W)
  // holding a started packet wins, and keeps the grant until its last beat
  // (or LIM beats). First beat shows 2 cycles after the IDLE decision; the
  // next decision is one cycle after the grant's final transfer.
  task automatic build_expected(input bit timed);
    beat_t mq[W][$];
    beat_t b;
    exp_t  e;
    int t, ptr, pick, n, left, c;
    left = 0;
    for (int i = 0; i < W; i++) begin
      mq[i] = chq[i];
      left += mq[i].size();
    end
    t = 0;
    ptr = 0;
    while (left > 0 && t < 50000) begin
      pick = -1;
      for (int k = 0; k < W; k++) begin
        c = (ptr + k) % W;
        if (pick < 0 && mq[c].size() > 0 && st[c] <= t) pick = c;
      end
      if (pick < 0) begin
        t++;
      end else begin
        n = 0;
        do begin
          b = mq[pick].pop_front();
          e.d = b.d; e.l = b.l; e.sel = pick;
          e.cyc = timed ? (t + 2 + n) : -1;
          sbq.push_back(e);
          n++;
          left--;
        end while (!b.l && n < LIM);
        t = t + n + 1;
        ptr = (pick + 1) % W;
      end
    end
  endtask

  task automatic zero_inputs();
    s_valid = '0;
    s_data  = '0;
    s_last  = '0;
    m_ready = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    n_tests++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== '0 || m_sel !== 3'd0 ||
        m_data !== '0 || m_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_%s: got m_valid=%b busy=%b s_ready=%b m_sel=%0d m_data=%h m_last=%b, want all zero",
               tag, m_valid, busy, s_ready, m_sel, m_data, m_last);
    end
  endtask

  task automatic do_reset();
    zero_inputs();
    rst_n = 1'b0;
    #1;
    check_reset_vals("pulse");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic drive_inputs();
    if (cyc >= stall_lo && cyc <= stall_hi) m_ready = 1'b0;
    else m_ready = ($urandom_range(99) >= stall_pct);
    for (int i = 0; i < W; i++) begin
      if (chq[i].size() > 0 && cyc >= st[i]) begin
        s_valid[i] = first_beat[i] || ($urandom_range(99) >= bubble_pct);
        s_data[i*DW +: DW] = chq[i][0].d;
        s_last[i] = chq[i][0].l;
      end else begin
        s_valid[i] = 1'b0;
        s_data[i*DW +: DW] = '0;
        s_last[i] = 1'b0;
      end
    end
  endtask

  // Runs one phase from an IDLE arbiter with ptr 0. abort_at >= 0 pulls
  // rst_n low asynchronously in that cycle and abandons the phase.
  task automatic run_phase(input bit do_rst, input bit timed,
                           input int abort_at, input int budget);
    logic [W-1:0] acc;
    beat_t b;
    bit done, aborted;
    if (do_rst) do_reset();
    else begin
      @(posedge clk);
      #2;
    end
    build_expected(timed);
    for (int i = 0; i < W; i++) first_beat[i] = 1'b1;
    cyc = 0;
    done = 1'b0;
    aborted = 1'b0;
    while (!done) begin
      drive_inputs();
      if (abort_at >= 0 && cyc == abort_at) begin
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async");
        for (int i = 0; i < W; i++) chq[i].delete();
        sbq.delete();
        zero_inputs();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        done = 1'b1;
        aborted = 1'b1;
      end else begin
        @(negedge clk);
        acc = s_valid & s_ready;
        @(posedge clk);
        for (int i = 0; i < W; i++) begin
          if (acc[i]) begin
            b = chq[i].pop_front();
            first_beat[i] = b.l;
          end
        end
        #2;
        cyc++;
        if (sbq.size() == 0 || cyc >= budget) done = 1'b1;
      end
    end
    if (!aborted) begin
      zero_inputs();
      repeat (3) @(posedge clk);
      #2;
      n_tests++;
      if (sbq.size() != 0) begin
        n_fail++;
        $display("FAIL phase_done: got %0d beats still expected after %0d cycles, want 0",
                 sbq.size(), cyc);
      end
    end
  endtask

  // Monitor: compares every output handshake against the expected queue
  // and checks hold/backpressure behaviour while the output is stalled.
  initial begin : monitor
    exp_t e;
    bit stalled;
    logic [DW-1:0] hd;
    logic hl;
    logic [2:0] hs;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          n_tests++;
          if (!(m_valid === 1'b1 && m_data === hd && m_last === hl && m_sel === hs)) begin
            n_fail++;
            $display("FAIL hold: got v=%b d=%h l=%b sel=%0d, want v=1 d=%h l=%b sel=%0d",
                     m_valid, m_data, m_last, m_sel, hd, hl, hs);
          end
        end
        if (m_valid === 1'b1 && m_ready === 1'b0) begin
          n_tests++;
          if (s_ready !== '0) begin
            n_fail++;
            $display("FAIL ready_full: got s_ready=%b, want 0", s_ready);
          end
        end
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
          n_tests++;
          if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL beat_extra: got d=%h l=%b sel=%0d at cycle %0d, want no beat",
                     m_data, m_last, m_sel, cyc);
          end else begin
            e = sbq.pop_front();
            if (m_data !== e.d || m_last !== e.l || int'(m_sel) != e.sel ||
                (e.cyc >= 0 && cyc != e.cyc)) begin
              n_fail++;
              $display("FAIL beat: got d=%h l=%b sel=%0d cyc=%0d, want d=%h l=%b sel=%0d cyc=%0d",
                       m_data, m_last, m_sel, cyc, e.d, e.l, e.sel, e.cyc);
            end
          end
        end
        stalled = (m_valid === 1'b1 && m_ready === 1'b0);
        hd = m_data;
        hl = m_last;
        hs = m_sel;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    rst_n = 1'b1;
    zero_inputs();
    @(posedge clk);
    #2;

    // Ch2, 3 beats: outputs at cycles 2..4, last only on the third.
    clear_cfg();
    add_pkt(2, 3);
    run_phase(1'b1, 1'b1, -1, 200);

    // Ch0 and ch5 together from reset: ch0 packet completes first.
    clear_cfg();
    add_pkt(0, 4);
    add_pkt(5, 2);
    run_phase(1'b1, 1'b1, -1, 200);

    // All channels, single-beat packets back to back: 0..7,0..7.
    clear_cfg();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < W; c++) add_pkt(c, 1);
    run_phase(1'b1, 1'b1, -1, 200);

    // Ch3, 4 beats, sink stalled in cycles 3..6.
    clear_cfg();
    add_pkt(3, 4);
    stall_lo = 3;
    stall_hi = 6;
    run_phase(1'b1, 1'b0, -1, 200);

    // Ch6 first moves ptr to 7; ch7 then beats ch1, and ptr wraps to 0.
    clear_cfg();
    add_pkt(6, 2);
    add_pkt(1, 2);
    add_pkt(7, 2);
    st[1] = 1;
    st[7] = 1;
    run_phase(1'b1, 1'b1, -1, 200);

    // Ch4 short packet (ptr -> 5), then reset mid-way through a long one.
    clear_cfg();
    add_pkt(4, 1);
    add_pkt(4, 6);
    run_phase(1'b1, 1'b1, 6, 200);
    // After reset ptr is 0 again, so ch4 wins over ch6.
    clear_cfg();
    add_pkt(4, 3);
    add_pkt(6, 2);
    run_phase(1'b0, 1'b1, -1, 200);

    // Long packet on ch1 with ch2 pending (interleaves with burst limit).
    clear_cfg();
    add_pkt(1, 10);
    add_pkt(2, 3);
    run_phase(1'b1, 1'b1, -1, 300);

    // Random traffic with sink stalls and mid-packet source bubbles.
    for (int r = 0; r < 6; r++) begin
      clear_cfg();
      for (int c = 0; c < W; c++)
        for (int p = $urandom_range(3); p > 0; p--) add_pkt(c, $urandom_range(6, 1));
      stall_pct  = 30;
      bubble_pct = BUB_MAX;
      run_phase(1'b1, 1'b0, -1, 4000);
    end

    // Random staggered arrivals, no stalls: exact cycle of every beat.
    for (int r = 0; r < 3; r++) begin
      clear_cfg();
      for (int c = 0; c < W; c++) begin
        st[c] = $urandom_range(12);
        for (int p = $urandom_range(2); p > 0; p--) add_pkt(c, $urandom_range(5, 1));
      end
      run_phase(1'b1, 1'b1, -1, 2000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
